playback_sequencer: RTL and testbench

//  Read side of the 16-slot note memory. On start, steps note_counter through stored slots with ld_play

---
 rtl/playback_sequencer_pkg.sv | 23 ++
 rtl/playback_sequencer_tone_gen.sv | 31 +++
 rtl/playback_sequencer.sv | 138 +++++++++++++
 tb/tb_playback_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/playback_sequencer_pkg.sv
// Shared definitions for the note-memory playback path: slot geometry, widths,
// default tempo and the sequencer state encoding.
package playback_sequencer_pkg;

  localparam int unsigned SlotCount = 16;
  localparam int unsigned SlotW     = $clog2(SlotCount);
  localparam int unsigned CountW    = SlotW + 1;
  localparam int unsigned FreqW     = 32;

  localparam int unsigned DefNoteCycles = 25_000_000;
  localparam int unsigned DefGapCycles  = 2_500_000;
  localparam int unsigned DefReadLat    = 2;
  localparam int unsigned DefStartAddr  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StPlay,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/playback_sequencer_tone_gen.sv
// Square-wave generator: toggles wave_o every half_period_i cycles while enabled.
// Dropping en_i clears the counter, so every enable starts low with a full half-period.
module playback_sequencer_tone_gen
  import playback_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [FreqW-1:0] half_period_i,
  output logic             wave_o
);

  logic [FreqW-1:0] cnt_q;
  logic             wave_q;

  always_ff @(posedge clk) begin
    // A zero half-period is a rest: hold the output low.
    if (!reset || !en_i || half_period_i == '0) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (cnt_q == half_period_i - FreqW'(1)) begin
      cnt_q  <= '0;
      wave_q <= ~wave_q;
    end else begin
      cnt_q <= cnt_q + FreqW'(1);
    end
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/playback_sequencer.sv
// Read side of the note memory: walks stored slots, fetches each frequency,
// plays it for a fixed duration, inserts a silent gap and advances.
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int unsigned NoteCycles = DefNoteCycles,
  parameter int unsigned GapCycles  = DefGapCycles,
  parameter int unsigned ReadLat    = DefReadLat,
  parameter int unsigned StartAddr  = DefStartAddr
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_en_i,
  input  logic [CountW-1:0] num_notes_i,
  input  logic [FreqW-1:0]  freq_in_i,
  output logic [SlotW-1:0]  note_counter_o,
  output logic              ld_play_o,
  output logic              audio_out_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [SlotW-1:0] StartSlot = SlotW'(StartAddr);
  localparam logic [31:0]      LatLast   = 32'(ReadLat);
  localparam logic [31:0]      NoteLast  = 32'(NoteCycles - 1);
  localparam logic [31:0]      GapLast   = 32'(GapCycles - 1);
  localparam bit               SkipGap   = (GapCycles == 0);

  state_e             state_q;
  logic [31:0]        dur_q;
  logic [FreqW-1:0]   freq_q;
  logic [CountW-1:0]  remaining_q;
  logic [CountW-1:0]  count_q;
  logic [SlotW-1:0]   slot_q;
  logic               busy_q;
  logic               done_q;
  logic               wave;
  logic               note_end;
  logic               advance;
  logic [CountW-1:0]  rem_dec;

  assign note_end = (state_q == StPlay) && (dur_q == NoteLast);
  assign advance  = (note_end && SkipGap) || ((state_q == StGap) && (dur_q == GapLast));
  assign rem_dec  = remaining_q - CountW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      dur_q       <= '0;
      freq_q      <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      slot_q      <= StartSlot;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (stop_i && state_q != StIdle) begin
      state_q <= StIdle;
      dur_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && !stop_i) begin
            busy_q <= 1'b1;
            dur_q  <= '0;
            if (num_notes_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q     <= StFetch;
              remaining_q <= num_notes_i;
              count_q     <= num_notes_i;
              slot_q      <= StartSlot;
            end
          end
        end
        // Hold for the address register plus RAM latency, then take the frequency.
        StFetch: begin
          if (dur_q == LatLast) begin
            freq_q  <= freq_in_i;
            dur_q   <= '0;
            state_q <= StPlay;
          end else begin
            dur_q <= dur_q + 32'd1;
          end
        end
        StPlay, StGap: begin
          if (advance) begin
            dur_q <= '0;
            if (rem_dec != '0) begin
              remaining_q <= rem_dec;
              slot_q      <= slot_q + SlotW'(1);
              state_q     <= StFetch;
            end else if (loop_en_i) begin
              remaining_q <= count_q;
              slot_q      <= StartSlot;
              state_q     <= StFetch;
            end else begin
              remaining_q <= rem_dec;
              state_q     <= StDone;
              done_q      <= 1'b1;
            end
          end else if (note_end) begin
            dur_q   <= '0;
            state_q <= StGap;
          end else begin
            dur_q <= dur_q + 32'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  playback_sequencer_tone_gen u_tone_gen (
    .clk          (clk),
    .reset        (reset),
    .en_i         (state_q == StPlay),
    .half_period_i(freq_q),
    .wave_o       (wave)
  );

  // The tone may toggle on the final PLAY edge; gating keeps the gap silent.
  assign audio_out_o    = wave & (state_q == StPlay);
  assign note_counter_o = slot_q;
  assign ld_play_o      = busy_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Randomized scoreboard bench for playback_sequencer: stimulus queues expected
// per-note events, a negedge monitor segments DUT activity into notes and compares.
module tb_playback_sequencer;
  import playback_sequencer_pkg::*;

  localparam int unsigned NoteCycles = 8;
  localparam int unsigned GapCycles  = 2;
  localparam int unsigned ReadLat    = 2;
  localparam int unsigned StartAddr  = 1;
  localparam int Win    = int'(ReadLat + 1 + NoteCycles + GapCycles);
  localparam int KNote  = 0;
  localparam int KDone  = 1;
  localparam int KAbort = 2;

  typedef struct {
    int kind;
    int slot;
    int high;
  } exp_t;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic        stop      = 1'b0;
  logic        loop_en   = 1'b0;
  logic [4:0]  num_notes = '0;
  logic [31:0] freq_in   = '0;
  logic [3:0]  note_counter;
  logic        ld_play, audio_out, busy, done;

  logic [31:0] mem [16];
  logic [3:0]  addr_q = '0;
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  playback_sequencer #(
    .NoteCycles(NoteCycles),
    .GapCycles (GapCycles),
    .ReadLat   (ReadLat),
    .StartAddr (StartAddr)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start),
    .stop_i        (stop),
    .loop_en_i     (loop_en),
    .num_notes_i   (num_notes),
    .freq_in_i     (freq_in),
    .note_counter_o(note_counter),
    .ld_play_o     (ld_play),
    .audio_out_o   (audio_out),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // Datapath model: registered address then registered RAM read.
  always @(posedge clk) begin
    addr_q  <= note_counter;
    freq_in <= mem[addr_q];
  end

  // Cycles the output is high during a note: in play cycle t it sits in half-period t/f.
  function automatic int hi_cycles(input int f);
    int h = 0;
    if (f == 0) return 0;
    for (int t = 0; t < int'(NoteCycles); t++) h += (t / f) % 2;
    return h;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic expect_event(input int kind, input int slot, input int high);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d slot %0d, expected no event", kind, slot);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == KNote && e.kind == KNote) begin
      chk("note_slot", slot, e.slot);
      chk("note_high_cycles", high, e.high);
    end
  endtask

  // Monitor: each busy period is a run of fixed-length note windows, then done or abort.
  int phase     = 0;
  int high_acc  = 0;
  int slot_obs  = 0;
  bit busy_prev = 1'b0;
  bit done_prev = 1'b0;

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (!busy_prev) phase = 0;
      if (done === 1'b1) begin
        expect_event(KDone, 0, 0);
      end else begin
        if (phase % Win == 0) begin
          slot_obs = int'(note_counter);
          high_acc = 0;
        end
        if (audio_out === 1'b1) high_acc++;
        if (phase % Win == Win - 1) begin
          chk("ld_play_during_note", int'(ld_play), 1);
          expect_event(KNote, slot_obs, high_acc);
        end
      end
      phase++;
    end else if (busy_prev && !done_prev) begin
      expect_event(KAbort, 0, 0);
    end
    busy_prev = (busy === 1'b1);
    done_prev = (done === 1'b1);
  end

  task automatic queue_notes(input int n, input int windows);
    for (int i = 0; i < windows; i++) begin
      int s = (int'(StartAddr) + (i % n)) % 16;
      exp_q.push_back('{KNote, s, hi_cycles(int'(mem[s]))});
    end
  endtask

  task automatic push_kind(input int kind);
    exp_q.push_back('{kind, 0, 0});
  endtask

  task automatic randomize_mem();
    for (int s = 0; s < 16; s++) mem[s] = 32'($urandom_range(0, 4));
  endtask

  // Returns during cycle 0 of the accepted run.
  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    num_notes = 5'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("events_drained", exp_q.size(), 0);
    chk("idle_after_run", int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_note_counter"}, int'(note_counter), int'(StartAddr));
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_ld_play"}, int'(ld_play), 0);
    chk({nm, "_audio_out"}, int'(audio_out), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  initial begin
    randomize_mem();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_reset_vals("reset");

    // Zero-length playback: done only, slot untouched.
    push_kind(KDone);
    pulse_start(0);
    chk("zero_done_pulse", int'(done), 1);
    wait_idle(20);
    chk("zero_note_counter", int'(note_counter), int'(StartAddr));

    // Three fixed notes including a rest.
    mem[1] = 32'd2;
    mem[2] = 32'd3;
    mem[3] = 32'd0;
    queue_notes(3, 3);
    push_kind(KDone);
    pulse_start(3);
    wait_idle(3 * Win + 20);

    // Full memory: slot wraps 15 -> 0 on the 16th note.
    randomize_mem();
    queue_notes(16, 16);
    push_kind(KDone);
    pulse_start(16);
    wait_idle(16 * Win + 20);

    // Stop during PLAY of note 2.
    randomize_mem();
    queue_notes(3, 1);
    push_kind(KAbort);
    pulse_start(3);
    repeat (20) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_audio_out", int'(audio_out), 0);
    chk("stop_ld_play", int'(ld_play), 0);
    chk("stop_done", int'(done), 0);
    wait_idle(20);

    // Looping over two slots, ended by stop after five full notes.
    randomize_mem();
    loop_en = 1'b1;
    queue_notes(2, 5);
    push_kind(KAbort);
    pulse_start(2);
    repeat (69) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    loop_en = 1'b0;
    wait_idle(20);

    // Start while busy is ignored.
    randomize_mem();
    queue_notes(3, 3);
    push_kind(KDone);
    pulse_start(3);
    repeat (15) @(posedge clk);
    #1 num_notes = 5'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(3 * Win + 20);

    // Reset during PLAY of note 2.
    randomize_mem();
    queue_notes(4, 1);
    push_kind(KAbort);
    pulse_start(4);
    repeat (18) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("midplay_reset");
    reset = 1'b1;
    wait_idle(20);

    // Random short runs.
    for (int r = 0; r < 4; r++) begin
      int n = int'($urandom_range(1, 6));
      randomize_mem();
      queue_notes(n, n);
      push_kind(KDone);
      pulse_start(n);
      wait_idle(n * Win + 20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
